gpio_cfg_chain_ctrl: RTL and testbench

Parametrised master for the serial pad-configuration chain that feeds a bank of per-pad GPIO control blocks. It holds a host-writable shadow image of NUM_PADS control words of CTRL_BITS each. On start it generates serial_clock, serial_data and serial_load to shift the whole image into the chain, then pulses load. It also captures the word returning on the chain tail for one selectable pad, so the previous chain content can be read back.

---
 rtl/gpio_cfg_chain_ctrl_if.sv | 43 ++++
 rtl/gpio_cfg_chain_ctrl.sv | 144 ++++++++++++++
 tb/tb_gpio_cfg_chain_ctrl.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/gpio_cfg_chain_ctrl_if.sv
`default_nettype none
// ============================================================================
// gpio_cfg_chain_ctrl_if : host config bus, status and serial chain pins
// Revision: 1.0
// ============================================================================
interface gpio_cfg_chain_ctrl_if #(
    parameter int NUM_PADS  = 15,
    parameter int CTRL_BITS = 16,
    parameter int CLK_DIV_W = 4,
    parameter int AW        = $clog2(NUM_PADS)
);
    logic [CLK_DIV_W-1:0] cfg_clk_div;
    logic                 cfg_wr_en;
    logic [AW-1:0]        cfg_wr_addr;
    logic [CTRL_BITS-1:0] cfg_wr_data;
    logic [AW-1:0]        cfg_rd_addr;
    logic                 cfg_start;
    logic                 cfg_abort;
    logic                 busy;
    logic                 done;
    logic                 aborted;
    logic                 wr_err;
    logic [CTRL_BITS-1:0] rdbk_data;
    logic                 serial_clock;
    logic                 serial_data;
    logic                 serial_load;
    logic                 serial_data_ret;

    modport slave (
        input  cfg_clk_div, cfg_wr_en, cfg_wr_addr, cfg_wr_data, cfg_rd_addr,
               cfg_start, cfg_abort, serial_data_ret,
        output busy, done, aborted, wr_err, rdbk_data,
               serial_clock, serial_data, serial_load
    );

    modport master (
        output cfg_clk_div, cfg_wr_en, cfg_wr_addr, cfg_wr_data, cfg_rd_addr,
               cfg_start, cfg_abort, serial_data_ret,
        input  busy, done, aborted, wr_err, rdbk_data,
               serial_clock, serial_data, serial_load
    );
endinterface
`default_nettype wire

// File: rtl/gpio_cfg_chain_ctrl.sv
`default_nettype none
// ============================================================================
// gpio_cfg_chain_ctrl : shifts a shadow image of pad control words into the
// GPIO configuration chain, pulses load, and captures one returned word.
// Revision: 1.0
// ============================================================================
module gpio_cfg_chain_ctrl #(
    parameter int                   NUM_PADS    = 15,
    parameter int                   CTRL_BITS   = 16,
    parameter int                   CLK_DIV_W   = 4,
    parameter logic [CTRL_BITS-1:0] CFG_DEFAULT = 16'h3000,
    parameter int                   AW          = $clog2(NUM_PADS)
) (
    input  wire logic            mclk,
    input  wire logic            resetn,
    gpio_cfg_chain_ctrl_if.slave bus
);
    localparam int c_total = NUM_PADS * CTRL_BITS;
    localparam int c_k_w   = $clog2(c_total + 1);
    localparam int c_bit_w = $clog2(CTRL_BITS);
    localparam logic [AW:0]        c_num_pads = (AW+1)'(NUM_PADS);
    localparam logic [AW-1:0]      c_last_pad = AW'(NUM_PADS - 1);
    localparam logic [c_bit_w-1:0] c_last_bit = c_bit_w'(CTRL_BITS - 1);
    localparam logic [c_k_w-1:0]   c_k_last   = c_k_w'(c_total - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SHIFT_LO = 3'd1,
        SHIFT_HI = 3'd2,
        LOAD     = 3'd3,
        FINISH   = 3'd4
    } state_t;

    state_t               r_state, w_state_nxt;
    logic [CLK_DIV_W-1:0] r_div, r_div_cnt;
    logic [c_k_w-1:0]     r_k;
    logic [AW-1:0]        r_pad, r_rd_addr;
    logic [c_bit_w-1:0]   r_bit;
    logic [CTRL_BITS-1:0] r_rdbk;
    logic [CTRL_BITS-1:0] r_shadow [NUM_PADS];
    logic r_busy, r_done, r_aborted, r_wr_err, r_sclk, r_sload, r_sdata_en;
    logic w_phase_end, w_abort, w_start;

    always_comb begin
        w_phase_end = (r_div_cnt == '0);
        w_abort     = r_busy && bus.cfg_abort;
        w_start     = !r_busy && bus.cfg_start;
        w_state_nxt = r_state;
        case (r_state)
            IDLE:     if (bus.cfg_start) w_state_nxt = SHIFT_LO;
            SHIFT_LO: if (w_phase_end)   w_state_nxt = SHIFT_HI;
            SHIFT_HI: if (w_phase_end)   w_state_nxt = (r_k == c_k_last) ? LOAD : SHIFT_LO;
            LOAD:     if (w_phase_end)   w_state_nxt = FINISH;
            FINISH:   if (w_phase_end)   w_state_nxt = IDLE;
            default:                     w_state_nxt = IDLE;
        endcase
        // Abort outranks both start and the normal phase advance.
        if (w_abort) w_state_nxt = IDLE;
    end

    always_ff @(posedge mclk) begin
        if (!resetn) begin
            r_state    <= IDLE;
            r_div      <= '0;
            r_div_cnt  <= '0;
            r_k        <= '0;
            r_pad      <= '0;
            r_bit      <= '0;
            r_rd_addr  <= '0;
            r_rdbk     <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_aborted  <= 1'b0;
            r_sclk     <= 1'b0;
            r_sload    <= 1'b0;
            r_sdata_en <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_done     <= 1'b0;
            r_aborted  <= w_abort;
            r_sclk     <= (w_state_nxt == SHIFT_HI);
            r_sload    <= (w_state_nxt == LOAD);
            r_sdata_en <= (w_state_nxt == SHIFT_LO) || (w_state_nxt == SHIFT_HI);
            if (w_abort) begin
                r_busy <= 1'b0;
            end else if (r_state == IDLE) begin
                if (bus.cfg_start) begin
                    r_busy    <= 1'b1;
                    r_div     <= bus.cfg_clk_div;
                    r_div_cnt <= bus.cfg_clk_div;
                    r_rd_addr <= bus.cfg_rd_addr;
                    r_k       <= '0;
                    r_pad     <= c_last_pad;
                    r_bit     <= c_last_bit;
                end
            end else if (w_phase_end) begin
                r_div_cnt <= r_div;
                // Returned bit k lands in the same pad/bit slot it was sent from.
                if (r_state == SHIFT_LO && r_pad == r_rd_addr)
                    r_rdbk[r_bit] <= bus.serial_data_ret;
                if (r_state == SHIFT_HI) begin
                    r_k <= r_k + c_k_w'(1);
                    if (r_bit == '0) begin
                        r_bit <= c_last_bit;
                        r_pad <= r_pad - AW'(1);
                    end else begin
                        r_bit <= r_bit - c_bit_w'(1);
                    end
                end
                if (r_state == FINISH) begin
                    r_done <= 1'b1;
                    r_busy <= 1'b0;
                end
            end else begin
                r_div_cnt <= r_div_cnt - CLK_DIV_W'(1);
            end
        end
    end

    always_ff @(posedge mclk) begin
        if (!resetn) begin
            r_wr_err <= 1'b0;
            for (int i = 0; i < NUM_PADS; i++) r_shadow[i] <= CFG_DEFAULT;
        end else begin
            if (bus.cfg_wr_en && r_busy)
                r_wr_err <= 1'b1;
            else if (w_start)
                r_wr_err <= 1'b0;
            if (bus.cfg_wr_en && !r_busy && ({1'b0, bus.cfg_wr_addr} < c_num_pads))
                r_shadow[bus.cfg_wr_addr] <= bus.cfg_wr_data;
        end
    end

    assign bus.busy         = r_busy;
    assign bus.done         = r_done;
    assign bus.aborted      = r_aborted;
    assign bus.wr_err       = r_wr_err;
    assign bus.rdbk_data    = r_rdbk;
    assign bus.serial_clock = r_sclk;
    assign bus.serial_load  = r_sload;
    // Data only moves while serial_clock is low, so this mux cannot race the clock.
    assign bus.serial_data  = r_sdata_en & r_shadow[r_pad][r_bit];
endmodule
`default_nettype wire

// File: tb/tb_gpio_cfg_chain_ctrl.sv
`default_nettype none
// ============================================================================
// tb_gpio_cfg_chain_ctrl : directed bench with a 12-bit chain model on the tail
// Revision: 1.0
// ============================================================================
module tb_gpio_cfg_chain_ctrl;
    logic mclk = 1'b0;
    logic resetn;
    always #5 mclk = ~mclk;

    gpio_cfg_chain_ctrl_if #(.NUM_PADS(3), .CTRL_BITS(4), .CLK_DIV_W(4)) bus ();

    gpio_cfg_chain_ctrl #(
        .NUM_PADS(3), .CTRL_BITS(4), .CLK_DIV_W(4), .CFG_DEFAULT(4'h3)
    ) dut (
        .mclk(mclk), .resetn(resetn), .bus(bus)
    );

    logic [11:0] sr;
    assign bus.serial_data_ret = sr[11];

    int n_tests = 0;
    int n_fail  = 0;
    int lat, rises, load_cyc, high_cyc, abort_cnt, done_seen;
    logic werr_after, abort_busy, abort_flag;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [3:0] d);
        bus.cfg_wr_en = 1'b1; bus.cfg_wr_addr = a; bus.cfg_wr_data = d;
        @(posedge mclk); #1;
        bus.cfg_wr_en = 1'b0;
    endtask

    task automatic pulse_start(input logic [3:0] div, input logic [1:0] rd);
        bus.cfg_clk_div = div; bus.cfg_rd_addr = rd; bus.cfg_start = 1'b1;
        @(posedge mclk); #1;
        bus.cfg_start = 1'b0; bus.cfg_wr_en = 1'b0;
    endtask

    // Steps cycles after a start, shifting the chain model on each serial_clock rise.
    // poke 1: write pad0 + start at the 3rd rise; poke 2: abort at the 5th rise.
    task automatic run(input int budget, input int poke);
        logic prev, active, fired;
        prev = 1'b0; active = 1'b0; fired = 1'b0;
        lat = 0; rises = 0; load_cyc = 0; high_cyc = 0; abort_cnt = 0; done_seen = 0;
        for (int c = 1; c <= budget; c++) begin
            @(posedge mclk); #1;
            if (bus.serial_clock && !prev) begin
                rises++;
                sr = {sr[10:0], bus.serial_data};
            end
            prev = bus.serial_clock;
            if (bus.serial_load) load_cyc++;
            if (bus.serial_clock) high_cyc++;
            if (bus.aborted) abort_cnt++;
            if (active) begin
                bus.cfg_wr_en = 1'b0; bus.cfg_start = 1'b0; bus.cfg_abort = 1'b0;
                werr_after = bus.wr_err; abort_busy = bus.busy; abort_flag = bus.aborted;
                active = 1'b0;
            end else if (!fired && poke == 1 && rises == 3) begin
                bus.cfg_wr_en = 1'b1; bus.cfg_wr_addr = 2'd0; bus.cfg_wr_data = 4'hF;
                bus.cfg_start = 1'b1; active = 1'b1; fired = 1'b1;
            end else if (!fired && poke == 2 && rises == 5) begin
                bus.cfg_abort = 1'b1; active = 1'b1; fired = 1'b1;
            end
            if (bus.done) begin
                lat = c; done_seen = 1;
                break;
            end
        end
    endtask

    initial begin
        resetn = 1'b0; sr = 12'h000;
        bus.cfg_clk_div = '0; bus.cfg_wr_en = 1'b0; bus.cfg_wr_addr = '0;
        bus.cfg_wr_data = '0; bus.cfg_rd_addr = '0; bus.cfg_start = 1'b0; bus.cfg_abort = 1'b0;
        repeat (3) @(posedge mclk);
        #1;
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_done", 32'(bus.done), 0);
        check("rst_wr_err", 32'(bus.wr_err), 0);
        check("rst_serial", {29'd0, bus.serial_clock, bus.serial_data, bus.serial_load}, 0);
        check("rst_rdbk", 32'(bus.rdbk_data), 0);
        resetn = 1'b1;
        @(posedge mclk); #1;

        // Default image, div=0
        sr = 12'h000;
        pulse_start(4'd0, 2'd0);
        check("busy_after_start", 32'(bus.busy), 1);
        run(200, 0);
        check("dflt_latency", 32'(lat + 1), 27);
        check("dflt_rises", 32'(rises), 12);
        check("dflt_load_cycles", 32'(load_cyc), 1);
        check("dflt_stream", 32'(sr), 32'h333);
        check("dflt_busy_end", 32'(bus.busy), 0);

        // Writes (pad0 together with start, out-of-range address ignored) + readback
        wr(2'd2, 4'hA); wr(2'd1, 4'h5); wr(2'd3, 4'hF);
        sr = 12'h333;
        bus.cfg_wr_en = 1'b1; bus.cfg_wr_addr = 2'd0; bus.cfg_wr_data = 4'hC;
        pulse_start(4'd0, 2'd1);
        run(200, 0);
        check("wr_stream", 32'(sr), 32'hA5C);
        check("wr_rdbk_first", 32'(bus.rdbk_data), 32'h3);
        pulse_start(4'd0, 2'd1);
        run(200, 0);
        check("wr_rdbk_second", 32'(bus.rdbk_data), 32'h5);
        check("wr_stream_again", 32'(sr), 32'hA5C);

        // Divider = 3
        pulse_start(4'd3, 2'd2);
        run(300, 0);
        check("div3_latency", 32'(lat + 1), 105);
        check("div3_load_cycles", 32'(load_cyc), 4);
        check("div3_high_cycles", 32'(high_cyc), 48);
        check("div3_rdbk", 32'(bus.rdbk_data), 32'hA);

        // Write and start while busy
        werr_after = 1'b0;
        pulse_start(4'd0, 2'd0);
        run(200, 1);
        check("busy_wr_err", 32'(werr_after), 1);
        check("busy_latency", 32'(lat + 1), 27);
        check("busy_stream", 32'(sr), 32'hA5C);
        check("busy_rdbk", 32'(bus.rdbk_data), 32'hC);
        check("busy_wr_err_sticky", 32'(bus.wr_err), 1);
        pulse_start(4'd0, 2'd0);
        check("start_clears_wr_err", 32'(bus.wr_err), 0);
        run(200, 0);
        check("after_clear_done", 32'(done_seen), 1);

        // Abort after the 5th rising edge
        abort_busy = 1'b1; abort_flag = 1'b0;
        pulse_start(4'd0, 2'd2);
        run(60, 2);
        check("abort_busy", 32'(abort_busy), 0);
        check("abort_pulse", 32'(abort_flag), 1);
        check("abort_pulse_count", 32'(abort_cnt), 1);
        check("abort_no_done", 32'(done_seen), 0);
        check("abort_no_load", 32'(load_cyc), 0);
        check("abort_rises", 32'(rises), 5);
        check("abort_idle_outputs", {29'd0, bus.serial_clock, bus.serial_data, bus.serial_load}, 0);

        // Reset during SHIFT_HI
        pulse_start(4'd1, 2'd0);
        for (int c = 0; c < 50 && !bus.serial_clock; c++) begin
            @(posedge mclk); #1;
        end
        check("reached_shift_hi", 32'(bus.serial_clock), 1);
        resetn = 1'b0;
        @(posedge mclk); #1;
        resetn = 1'b1;
        check("mid_rst_busy", 32'(bus.busy), 0);
        check("mid_rst_serial", {29'd0, bus.serial_clock, bus.serial_data, bus.serial_load}, 0);
        check("mid_rst_flags", {29'd0, bus.done, bus.aborted, bus.wr_err}, 0);
        check("mid_rst_rdbk", 32'(bus.rdbk_data), 0);
        sr = 12'h000;
        pulse_start(4'd0, 2'd0);
        run(200, 0);
        check("mid_rst_stream", 32'(sr), 32'h333);
        check("mid_rst_latency", 32'(lat + 1), 27);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
